// File: rtl/dds_pkg.sv
// Shared DDS definitions: default widths, waveform select codes, DAC midpoint.
// Used by the wave shaper RTL and by the DDS controller/shaper benches.
// No ports; constants and types only.
package dds_pkg;

  localparam int DDS_ADDR_W = 6;
  localparam int DDS_DATA_W = 7;
  localparam int DDS_OUT_W  = DDS_DATA_W + 1;

  // Offset-binary midpoint of the DAC code (zero amplitude).
  localparam logic [DDS_OUT_W-1:0] DDS_MID = DDS_OUT_W'(1) << DDS_DATA_W;

  typedef enum logic [1:0] {
    WAVE_SINE = 2'b00,
    WAVE_TRI  = 2'b01,
    WAVE_SQR  = 2'b10,
    WAVE_MUTE = 2'b11
  } wave_t;

  // Falling quarters walk the quarter-wave table backwards.
  function automatic logic [DDS_ADDR_W-1:0] mirror_addr(input logic phase_pose,
                                                        input logic [DDS_ADDR_W-1:0] addr);
    return phase_pose ? ~addr : addr;
  endfunction

endpackage

// File: rtl/dds_wave_shaper_if.sv
// Sample bus between the DDS phase controller and the wave shaper, plus DAC output side.
// Latency: none (wires only).
// Backpressure: none; in_valid/out_valid qualify samples, the shaper always accepts.
// master: drives phase/control fields and in_valid, receives dac_out/out_valid/zero_cross.
// slave : the shaper side.
interface dds_wave_shaper_if #(
  parameter int ADDR_W = dds_pkg::DDS_ADDR_W,
  parameter int DATA_W = dds_pkg::DDS_DATA_W
);

  logic              in_valid;
  logic              sign_bit;
  logic              phase_pose;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        wave_sel;
  logic [1:0]        amp_shift;
  logic [DATA_W:0]   dac_out;
  logic              out_valid;
  logic              zero_cross;

  modport master (
    output in_valid, sign_bit, phase_pose, addr, wave_sel, amp_shift,
    input  dac_out, out_valid, zero_cross
  );

  modport slave (
    input  in_valid, sign_bit, phase_pose, addr, wave_sel, amp_shift,
    output dac_out, out_valid, zero_cross
  );

endinterface

// File: rtl/dds_wave_shaper_rom.sv
// Quarter-wave sine table, synchronous read, no reset on the data path.
// Latency: 1 clock (addr sampled at edge N, data valid after edge N).
// Backpressure: none; reads every cycle.
// Ports: clk (rising edge), addr (ADDR_W), data (DATA_W).
// Table entries are round(127*sin(pi/2*i/63)) for the default 6-bit address / 7-bit data
// geometry; the endpoints are exact (entry 0 = 0, entry 63 = full scale) so a quarter
// starts at zero and ends on the peak.
module quarter_sine_rom #(
  parameter int ADDR_W = dds_pkg::DDS_ADDR_W,
  parameter int DATA_W = dds_pkg::DDS_DATA_W
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  localparam logic [6:0] TABLE [0:63] = '{
    7'd0,   7'd3,   7'd6,   7'd9,   7'd13,  7'd16,  7'd19,  7'd22,
    7'd25,  7'd28,  7'd31,  7'd34,  7'd37,  7'd40,  7'd43,  7'd46,
    7'd49,  7'd52,  7'd55,  7'd58,  7'd61,  7'd64,  7'd66,  7'd69,
    7'd72,  7'd74,  7'd77,  7'd79,  7'd82,  7'd84,  7'd86,  7'd89,
    7'd91,  7'd93,  7'd95,  7'd97,  7'd99,  7'd101, 7'd103, 7'd105,
    7'd107, 7'd108, 7'd110, 7'd112, 7'd113, 7'd114, 7'd116, 7'd117,
    7'd118, 7'd119, 7'd120, 7'd121, 7'd122, 7'd123, 7'd124, 7'd124,
    7'd125, 7'd126, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127, 7'd127
  };

  always_ff @(posedge clk) begin
    data <= TABLE[addr];
  end

endmodule

// File: rtl/dds_wave_shaper.sv
// Wave shaper: mirror phase address, build sine/triangle/square/mute magnitude, scale, apply sign,
//   emit offset-binary DAC code with a zero-crossing strobe.
// Latency: 3 clocks (S1 capture, S2 magnitude, S3 DAC register), throughput 1 sample/clk.
// Backpressure: none; in_valid bubbles ride the pipe, dac_out holds through them.
// Ports: clk, reset (sync, active-high), bus (slave side of dds_wave_shaper_if).
module dds_wave_shaper
  import dds_pkg::*;
#(
  parameter int ADDR_W = DDS_ADDR_W,
  parameter int DATA_W = DDS_DATA_W
) (
  input  logic               clk,
  input  logic               reset,
  dds_wave_shaper_if.slave   bus
);

  localparam int OUT_W  = DATA_W + 1;
  localparam int TRI_SH = DATA_W - ADDR_W;
  localparam logic [OUT_W-1:0] MID_C = OUT_W'(1) << DATA_W;

  // ---------------- S1: capture and mirror ----------------
  logic              v1;
  logic [ADDR_W-1:0] maddr1;
  logic              sign1;
  wave_t             wave1;
  logic [1:0]        amp1;

  always_ff @(posedge clk) begin
    if (reset) begin
      v1     <= 1'b0;
      maddr1 <= '0;
      sign1  <= 1'b0;
      wave1  <= WAVE_MUTE;
      amp1   <= '0;
    end else begin
      v1     <= bus.in_valid;
      maddr1 <= bus.phase_pose ? ~bus.addr : bus.addr;
      sign1  <= bus.sign_bit;
      wave1  <= wave_t'(bus.wave_sel);
      amp1   <= bus.amp_shift;
    end
  end

  // ---------------- S2: magnitude ----------------
  // The sine path is registered inside the ROM; the synthesised shapes are registered here
  // so both arrive on the same edge and the select happens after the registers.
  logic [DATA_W-1:0] rom_q;
  logic [DATA_W-1:0] synth_mag;
  logic [DATA_W-1:0] synth2;
  logic              v2;
  logic              sign2;
  wave_t             wave2;
  logic [1:0]        amp2;
  logic [DATA_W-1:0] mag2;

  quarter_sine_rom #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_rom (
    .clk  (clk),
    .addr (maddr1),
    .data (rom_q)
  );

  always_comb begin
    synth_mag = '0;
    case (wave1)
      WAVE_TRI: synth_mag = DATA_W'(maddr1) << TRI_SH;
      WAVE_SQR: synth_mag = {DATA_W{1'b1}};
      default:  synth_mag = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v2     <= 1'b0;
      sign2  <= 1'b0;
      wave2  <= WAVE_MUTE;
      amp2   <= '0;
      synth2 <= '0;
    end else begin
      v2     <= v1;
      sign2  <= sign1;
      wave2  <= wave1;
      amp2   <= amp1;
      synth2 <= synth_mag;
    end
  end

  assign mag2 = (wave2 == WAVE_SINE) ? rom_q : synth2;

  // ---------------- S3: scale, sign, DAC register ----------------
  // Magnitude never exceeds 2^DATA_W-1, so MID +/- m stays within [1, 2^OUT_W-1].
  logic [OUT_W-1:0] scaled;
  logic [OUT_W-1:0] dac_next;
  logic             neg_next;
  logic [OUT_W-1:0] dac_q;
  logic             out_valid_q;
  logic             zero_cross_q;
  logic             prev_neg;
  logic             first_sample;

  always_comb begin
    scaled   = OUT_W'(mag2) >> amp2;
    dac_next = sign2 ? (MID_C - scaled) : (MID_C + scaled);
    // A zero magnitude lands exactly on MID and counts as positive.
    neg_next = (dac_next < MID_C);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dac_q        <= MID_C;
      out_valid_q  <= 1'b0;
      zero_cross_q <= 1'b0;
      prev_neg     <= 1'b0;
      first_sample <= 1'b1;
    end else begin
      out_valid_q <= v2;
      if (v2) begin
        dac_q        <= dac_next;
        zero_cross_q <= !first_sample && (neg_next != prev_neg);
        prev_neg     <= neg_next;
        first_sample <= 1'b0;
      end else begin
        zero_cross_q <= 1'b0;
      end
    end
  end

  assign bus.dac_out    = dac_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.zero_cross = zero_cross_q;

endmodule

// File: tb/tb_dds_wave_shaper.sv
// Bench for dds_wave_shaper: directed steps plus a scoreboard of expected DAC samples.
module tb_dds_wave_shaper;
  import dds_pkg::*;

  logic clk = 1'b0;
  logic reset;

  dds_wave_shaper_if #(.ADDR_W(6), .DATA_W(7)) bus ();

  dds_wave_shaper #(.ADDR_W(6), .DATA_W(7)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] dac;
    logic       zc;
  } exp_t;

  exp_t       sb_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         zc_seen  = 0;
  logic [7:0] held_dac = 8'd128;
  logic       m_prev   = 1'b0;
  logic       m_first  = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Golden quarter-wave sine: round half up, with a tiny bias so the exact 63.5 entry rounds up.
  function automatic int gold_sine(input int i);
    real r;
    r = 127.0 * $sin(3.14159265358979 * i / 126.0);
    return $rtoi(r + 0.5 + 1.0e-6);
  endfunction

  function automatic int model_dac(input logic s, input logic pp, input int a,
                                   input logic [1:0] w, input int sh);
    int ma, mag, m;
    ma = pp ? (63 - a) : a;
    case (w)
      2'b00:   mag = gold_sine(ma);
      2'b01:   mag = ma * 2;
      2'b10:   mag = 127;
      default: mag = 0;
    endcase
    m = mag >> sh;
    return s ? (128 - m) : (128 + m);
  endfunction

  task automatic push_exp(input int d);
    exp_t e;
    logic neg;
    neg     = (d < 128);
    e.dac   = d[7:0];
    e.zc    = !m_first && (neg != m_prev);
    m_prev  = neg;
    m_first = 1'b0;
    sb_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic pp, input logic [5:0] a,
                       input logic [1:0] w, input logic [1:0] sh, input int exp_dac);
    step();
    bus.in_valid   = v;
    bus.sign_bit   = s;
    bus.phase_pose = pp;
    bus.addr       = a;
    bus.wave_sel   = w;
    bus.amp_shift  = sh;
    if (v) push_exp(exp_dac);
  endtask

  task automatic idle();
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb_q.size() != 0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (sb_q.size() != 0) check("drain_timeout", sb_q.size(), 0);
  endtask

  task automatic flush_model();
    sb_q.delete();
    m_prev   = 1'b0;
    m_first  = 1'b1;
    held_dac = 8'd128;
  endtask

  // Output monitor: pops the scoreboard on valid samples, checks hold/no-strobe on bubbles.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (bus.out_valid) begin
        if (bus.zero_cross) zc_seen++;
        if (sb_q.size() == 0) begin
          check("spurious_out_valid", bus.out_valid, 0);
        end else begin
          e = sb_q.pop_front();
          check("dac_out", bus.dac_out, e.dac);
          check("zero_cross", bus.zero_cross, e.zc);
          held_dac = e.dac;
        end
      end else begin
        check("bubble_hold", bus.dac_out, held_dac);
        check("bubble_zc", bus.zero_cross, 0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    bus.in_valid   = 1'b0;
    bus.sign_bit   = 1'b0;
    bus.phase_pose = 1'b0;
    bus.addr       = '0;
    bus.wave_sel   = 2'b11;
    bus.amp_shift  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_dac", bus.dac_out, 128);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_zero_cross", bus.zero_cross, 0);
    step();
    reset = 1'b0;
    flush_model();

    // 1: latency and endpoints of the rising quarter
    drive(1, 0, 0, 6'd0, WAVE_SINE, 0, 128);
    idle();
    @(negedge clk); check("lat_edge1", bus.out_valid, 0);
    @(negedge clk); check("lat_edge2", bus.out_valid, 0);
    @(negedge clk); check("lat_edge3", bus.out_valid, 1);
    check("lat_dac", bus.dac_out, 128);
    drive(1, 0, 0, 6'd63, WAVE_SINE, 0, 255);

    // 2: mirror and negative half
    drive(1, 0, 1, 6'd0,  WAVE_SINE, 0, 255);
    drive(1, 1, 0, 6'd63, WAVE_SINE, 0, 1);

    // 3: amplitude shift and synthesised shapes
    drive(1, 0, 0, 6'd63, WAVE_SINE, 1, 191);
    drive(1, 0, 0, 6'd32, WAVE_TRI,  0, 192);
    drive(1, 1, 0, 6'd0,  WAVE_SQR,  0, 1);
    drive(1, 0, 0, 6'd17, WAVE_MUTE, 0, 128);
    idle();
    drain();

    // 4: one full 256-sample period as produced by the phase controller
    zc_seen = 0;
    for (int p = 0; p < 256; p++) begin
      drive(1, p[7], p[6], p[5:0], WAVE_SINE, 0, model_dac(p[7], p[6], p[5:0], WAVE_SINE, 0));
    end
    idle();
    drain();
    check("zc_per_period", zc_seen, 2);

    // 5: bubble in the middle of a stream
    drive(1, 0, 0, 6'd10, WAVE_TRI, 0, 148);
    drive(0, 1, 0, 6'd63, WAVE_SQR, 0, 0);
    drive(1, 1, 0, 6'd10, WAVE_TRI, 0, 108);
    idle();
    @(negedge clk); check("bubble_v_a", bus.out_valid, 1);
    @(negedge clk); check("bubble_v_gap", bus.out_valid, 0);
    check("bubble_dac_gap", bus.dac_out, 148);
    @(negedge clk); check("bubble_v_c", bus.out_valid, 1);
    check("bubble_dac_c", bus.dac_out, 108);
    drain();

    // 6: reset with samples in flight
    drive(1, 0, 0, 6'd63, WAVE_SINE, 0, 255);
    drive(1, 1, 0, 6'd63, WAVE_SINE, 0, 1);
    step();
    reset          = 1'b1;
    bus.in_valid   = 1'b1;
    bus.sign_bit   = 1'b0;
    bus.addr       = 6'd40;
    flush_model();
    step();
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_valid", bus.out_valid, 0);
    check("post_rst_dac", bus.dac_out, 128);
    drive(1, 1, 0, 6'd63, WAVE_SINE, 0, 1);
    drive(1, 1, 0, 6'd32, WAVE_SINE, 0, 37);
    drive(1, 0, 0, 6'd5,  WAVE_SINE, 0, 144);
    idle();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
